// File: rtl/iomem_display_ctrl.sv
// iomem slave for a 32-LED bank and a 4-digit multiplexed 7-segment display.
// Holds the pattern registers, a global PWM brightness sequencer and the digit-scan sequencer.
module iomem_display_ctrl #(
  parameter logic [7:0]  PAGE      = 8'h03,
  parameter int unsigned SCAN_BITS = 15,
  parameter int unsigned PWM_BITS  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [31:0] leds,
  output logic [11:0] segs
);

  localparam logic [PWM_BITS-1:0]  PWM_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0]  PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [SCAN_BITS-1:0] PRE_TOP = {SCAN_BITS{1'b1}};
  localparam logic [SCAN_BITS-1:0] PRE_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

  logic [31:0]          leds_reg_r;
  logic [31:0]          segs_reg_r;
  logic [PWM_BITS-1:0]  duty_r;
  logic                 enable_r;
  logic                 frame_r;
  logic [1:0]           digit_r;
  logic [SCAN_BITS-1:0] pre_r;
  logic [PWM_BITS-1:0]  pwm_r;

  logic        hit_s, wr_s, frame_clr_s, wrap_s, frame_set_s, act_s;
  logic [1:0]  sel_s;
  logic [31:0] rd_s, ctrl_rd_s;
  logic [7:0]  seg_byte_s;
  logic [3:0]  anode_s;
  logic        unused_addr_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] nxt,
                                              input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_addr_s = ^{iomem_addr[23:4], iomem_addr[1:0]};

  // Bus decode, read mux and scan/PWM next-state terms.
  always_comb begin
    hit_s       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == PAGE);
    wr_s        = hit_s && (iomem_wstrb != 4'b0000);
    sel_s       = iomem_addr[3:2];
    frame_clr_s = wr_s && (sel_s == 2'd3) && iomem_wstrb[0] && iomem_wdata[2];
    wrap_s      = (pre_r == PRE_TOP);
    frame_set_s = wrap_s && (digit_r == 2'd3);
    act_s       = enable_r && (pwm_r < duty_r);
    anode_s     = ~(4'b0001 << digit_r);
    ctrl_rd_s                = 32'h0000_0000;
    ctrl_rd_s[PWM_BITS-1:0]  = duty_r;
    ctrl_rd_s[8]             = enable_r;
    case (sel_s)
      2'd0:    rd_s = leds_reg_r;
      2'd1:    rd_s = segs_reg_r;
      2'd2:    rd_s = ctrl_rd_s;
      2'd3:    rd_s = {29'h0000_0000, frame_r, digit_r};
      default: rd_s = 32'h0000_0000;
    endcase
    case (digit_r)
      2'd0:    seg_byte_s = segs_reg_r[7:0];
      2'd1:    seg_byte_s = segs_reg_r[15:8];
      2'd2:    seg_byte_s = segs_reg_r[23:16];
      2'd3:    seg_byte_s = segs_reg_r[31:24];
      default: seg_byte_s = 8'h00;
    endcase
  end

  // Bus handshake and register writes; rdata captures the pre-write value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0000_0000;
      leds_reg_r  <= 32'h0000_0000;
      segs_reg_r  <= 32'h0000_0000;
      duty_r      <= {PWM_BITS{1'b0}};
      enable_r    <= 1'b0;
    end else begin
      iomem_ready <= hit_s;
      if (hit_s) iomem_rdata <= rd_s;
      if (wr_s) begin
        case (sel_s)
          2'd0: leds_reg_r <= merge_bytes(leds_reg_r, iomem_wdata, iomem_wstrb);
          2'd1: segs_reg_r <= merge_bytes(segs_reg_r, iomem_wdata, iomem_wstrb);
          2'd2: begin
            if (iomem_wstrb[0]) duty_r <= iomem_wdata[PWM_BITS-1:0];
            if (iomem_wstrb[1]) enable_r <= iomem_wdata[8];
          end
          default: ;
        endcase
      end
    end
  end

  // Free-running PWM and scan counters; frame set takes priority over clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_r   <= {PWM_BITS{1'b0}};
      pre_r   <= {SCAN_BITS{1'b0}};
      digit_r <= 2'd0;
      frame_r <= 1'b0;
    end else begin
      pwm_r <= (pwm_r == PWM_TOP) ? {PWM_BITS{1'b0}} : pwm_r + PWM_ONE;
      pre_r <= pre_r + PRE_ONE;
      if (wrap_s) digit_r <= digit_r + 2'd1;
      if (frame_set_s)      frame_r <= 1'b1;
      else if (frame_clr_s) frame_r <= 1'b0;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      leds <= 32'h0000_0000;
      segs <= 12'hF00;
    end else begin
      leds       <= act_s ? leds_reg_r : 32'h0000_0000;
      segs[11:8] <= act_s ? anode_s : 4'hF;
      segs[7:0]  <= seg_byte_s;
    end
  end

endmodule

// File: tb/tb_iomem_display_ctrl.sv
// Scenario bench for iomem_display_ctrl with a short scan prescaler (digit every 4 cycles).
module tb_iomem_display_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0000_0000;
  logic [31:0] iomem_wdata = 32'h0000_0000;
  logic [31:0] iomem_rdata;
  logic [31:0] leds;
  logic [11:0] segs;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [11:0] seg_q[$];

  iomem_display_ctrl #(.PAGE(8'h03), .SCAN_BITS(2), .PWM_BITS(8)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .leds(leds), .segs(segs)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // One bus access; lat = cycles to ready (0 = none), held = ready one cycle later.
  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] r, output int lat, output logic held);
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    lat = 0; r = iomem_rdata;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin lat = i; r = iomem_rdata; break; end
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    held = iomem_ready;
  endtask

  // Return at the first negedge where the anodes newly show value an.
  task automatic sync_anode(input logic [3:0] an, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (segs[11:8] != an) break;
    end
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (segs[11:8] == an) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] r, e; int lat; logic held;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (leds !== 32'h0) begin miscompares++; $display("FAIL reset_leds: got %h want 00000000", leds); end
    vectors++; if (segs !== 12'hF00) begin miscompares++; $display("FAIL reset_segs: got %h want f00", segs); end
    vectors++; if (iomem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", iomem_ready); end
    resetn = 1'b1;
    exp_q.push_back(32'h0000_0000);
    bus_xfer(32'h0300_000C, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL reset_stat: got %h want %h", r, e); end
  endtask

  task automatic test_handshake;
    logic [31:0] r, e; int lat; logic held;
    exp_q.push_back(32'h0000_0000);
    bus_xfer(32'h0300_0000, 4'b0101, 32'h1234_5678, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL wr_latency: got %0d want 1", lat); end
    vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL wr_ready_width: got %b want 0", held); end
    vectors++; if (r !== e) begin miscompares++; $display("FAIL wr_prevalue: got %h want %h", r, e); end
    exp_q.push_back(32'h0034_0078);
    bus_xfer(32'h0300_0000, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL rd_latency: got %0d want 1", lat); end
    vectors++; if (r !== e) begin miscompares++; $display("FAIL rd_strobed: got %h want %h", r, e); end
    exp_q.push_back(32'h0034_0078);
    bus_xfer(32'h03FF_FFF3, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL rd_alias: got %h want %h", r, e); end
    bus_xfer(32'h0400_0000, 4'hF, 32'hFFFF_FFFF, r, lat, held);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL miss_ready: got %0d want 0", lat); end
    vectors++; if (iomem_rdata !== 32'h0034_0078) begin miscompares++; $display("FAIL miss_rdata_hold: got %h want 00340078", iomem_rdata); end
  endtask

  task automatic test_pwm;
    logic [31:0] r, e; int lat; logic held; int cnt, bad;
    bus_xfer(32'h0300_0000, 4'hF, 32'hFFFF_FFFF, r, lat, held);
    bus_xfer(32'h0300_0008, 4'hF, 32'h0000_0100, r, lat, held);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (leds !== 32'h0) cnt++; end
    vectors++; if (cnt !== 0) begin miscompares++; $display("FAIL pwm_duty0: got %0d on-cycles want 0", cnt); end
    bus_xfer(32'h0300_0008, 4'hF, 32'h0000_01FF, r, lat, held);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (leds !== 32'hFFFF_FFFF) cnt++; end
    vectors++; if (cnt !== 0) begin miscompares++; $display("FAIL pwm_duty255: got %0d off-cycles want 0", cnt); end
    bus_xfer(32'h0300_0008, 4'hF, 32'hFFFF_F140, r, lat, held);
    exp_q.push_back(32'h0000_0140);
    bus_xfer(32'h0300_0008, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL ctrl_readback: got %h want %h", r, e); end
    cnt = 0; bad = 0;
    for (int i = 0; i < 510; i++) begin
      @(negedge clk);
      if (leds === 32'hFFFF_FFFF) cnt++;
      else if (leds !== 32'h0) bad++;
    end
    vectors++; if (cnt !== 128) begin miscompares++; $display("FAIL pwm_duty64: got %0d on-cycles want 128", cnt); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pwm_levels: got %0d partial cycles want 0", bad); end
  endtask

  task automatic test_scan;
    logic [31:0] r; int lat; logic held; bit ok; logic [11:0] e;
    bus_xfer(32'h0300_0004, 4'hF, 32'h4433_2211, r, lat, held);
    bus_xfer(32'h0300_0008, 4'hF, 32'h0000_01FF, r, lat, held);
    sync_anode(4'hE, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL scan_sync: got timeout want anode e"); end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) seg_q.push_back(12'hE11);
      for (int j = 0; j < 4; j++) seg_q.push_back(12'hD22);
      for (int j = 0; j < 4; j++) seg_q.push_back(12'hB33);
      for (int j = 0; j < 4; j++) seg_q.push_back(12'h744);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 0) @(negedge clk);
      e = seg_q.pop_front();
      vectors++; if (segs !== e) begin miscompares++; $display("FAIL scan_seq[%0d]: got %h want %h", i, segs, e); end
    end
  endtask

  task automatic test_frame;
    logic [31:0] r, e; int lat; logic held; bit ok;
    // Clear well away from a wrap, then read: flag 0, digit 1.
    sync_anode(4'hE, ok);
    bus_xfer(32'h0300_000C, 4'b0001, 32'h0000_0004, r, lat, held);
    exp_q.push_back(32'h0000_0001);
    bus_xfer(32'h0300_000C, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (!ok || r !== e) begin miscompares++; $display("FAIL frame_clear: got %h want %h", r, e); end
    // Next wrap sets it again.
    sync_anode(4'hE, ok);
    exp_q.push_back(32'h0000_0004);
    bus_xfer(32'h0300_000C, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (!ok || r !== e) begin miscompares++; $display("FAIL frame_set: got %h want %h", r, e); end
    bus_xfer(32'h0300_000C, 4'b0001, 32'h0000_0004, r, lat, held);
    exp_q.push_back(32'h0000_0002);
    bus_xfer(32'h0300_000C, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL frame_reclear: got %h want %h", r, e); end
    // Clear lands on the wrap edge: set must win.
    sync_anode(4'h7, ok);
    @(posedge clk);
    exp_q.push_back(32'h0000_0003);
    bus_xfer(32'h0300_000C, 4'b0001, 32'h0000_0004, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (!ok || r !== e) begin miscompares++; $display("FAIL frame_race_pre: got %h want %h", r, e); end
    exp_q.push_back(32'h0000_0004);
    bus_xfer(32'h0300_000C, 4'h0, 32'h0, r, lat, held);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL frame_set_wins: got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, e; int lat; logic held; int seen;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0300_000C; addrs[1] = 32'h0300_0000;
    addrs[2] = 32'h0300_0004; addrs[3] = 32'h0300_0008;
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'hA5A5_A5A5;
    #2 resetn = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (iomem_ready !== 1'b0) seen++; end
    vectors++; if (leds !== 32'h0 || segs !== 12'hF00) begin miscompares++; $display("FAIL midrst_pins: got %h/%h want 00000000/f00", leds, segs); end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0000_0000);
      bus_xfer(addrs[i], 4'h0, 32'h0, r, lat, held);
      e = exp_q.pop_front();
      vectors++; if (r !== e) begin miscompares++; $display("FAIL midrst_reg%0d: got %h want %h", i, r, e); end
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_ready: got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_pwm();
    test_scan();
    test_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
